// File: rtl/uart_byte_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_byte_tx_if                                       |
// | Brief    : Byte push handshake between upstream logic and the    |
// |            UART transmitter FIFO.                                |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface uart_byte_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_overflow;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_overflow
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_byte_tx                                          |
// | Brief    : 8N1 UART byte transmitter fed by a small circular     |
// |            FIFO; frames go out back-to-back with no idle gap.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module uart_byte_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_byte_tx_if.slave                 tx_if,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] c_BIT_END  = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   c_CNT1     = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   c_FULL     = (PTR_W + 1)'(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ready;
    logic             r_overflow;

    // Serialiser state
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_empty;
    logic             w_bit_end;
    logic [PTR_W:0]   w_count_nxt;
    logic [2:0]       w_next_idx;

    assign w_push       = tx_if.tx_valid & r_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_bit_end    = (r_baud_cnt == c_BIT_END);
    assign w_next_idx   = r_bit_idx + 3'd1;

    // A pop happens either from IDLE or at the final cycle of a stop bit.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == c_ST_IDLE) || ((r_state == c_ST_STOP) && w_bit_end));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT1;
            2'b01:   w_count_nxt = r_count - c_CNT1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count    <= w_count_nxt;
            // Ready tracks the post-edge occupancy so a full FIFO refuses
            // pushes even on an edge where a pop frees a slot.
            r_ready    <= (w_count_nxt != c_FULL);
            r_overflow <= tx_if.tx_valid & ~r_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= c_ST_START;
                        r_txd   <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_ST_DATA;
                        r_txd      <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_txd     <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= c_ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    assign tx_if.tx_ready    = r_ready;
    assign tx_if.tx_overflow = r_overflow;
    assign txd               = r_txd;
    assign busy              = (r_state != c_ST_IDLE) || !w_fifo_empty;
    assign fifo_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_uart_byte_tx                                       |
// | Brief    : Directed + random bench for uart_byte_tx against a    |
// |            frame-timeline reference model.                       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_uart_byte_tx;

    localparam int CLK_FREQ   = 1000;
    localparam int BAUD       = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYC    = CLK_FREQ / BAUD;
    localparam int FRAME      = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    uart_byte_tx_if bus ();

    uart_byte_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (bus),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: queued bytes plus the number of cycles left in the
    // frame currently on the line (0 means the line is idle).
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_left;
    logic       m_ovf;

    int n_checks;
    int n_fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int pos;
        if (m_left == 0) return 1'b1;
        pos = (FRAME - m_left) / BIT_CYC;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_cur[pos-1];
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic m_ready;
        logic do_push;
        logic do_pop;
        bus.tx_valid = v;
        bus.tx_data  = d;
        rst          = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            m_ready = (m_q.size() != FIFO_DEPTH);
            do_push = v && m_ready;
            m_ovf   = v && !m_ready;
            do_pop  = (m_q.size() > 0) && (m_left <= 1);
            if (do_pop) begin
                m_cur  = m_q.pop_front();
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (do_push) m_q.push_back(d);
        end
        #1;
        check("txd",         {31'd0, txd},             {31'd0, exp_txd()});
        check("busy",        {31'd0, busy},            {31'd0, (m_left > 0) || (m_q.size() > 0)});
        check("fifo_count",  {29'd0, fifo_count},      32'(m_q.size()));
        check("tx_ready",    {31'd0, bus.tx_ready},    {31'd0, m_q.size() != FIFO_DEPTH});
        check("tx_overflow", {31'd0, bus.tx_overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        m_left       = 0;
        m_ovf        = 1'b0;
        m_cur        = 8'h00;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst          = 1'b1;

        // Reset and idle line
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(3);

        // Single byte 0xA5
        step(1'b1, 8'hA5, 1'b0);
        idle(FRAME + 10);

        // Four-byte burst, frames back to back
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        idle(4 * FRAME + 10);

        // Six pushes: the sixth overflows and is dropped
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        idle(5 * FRAME + 10);

        // Hold valid while full: each pop admits exactly one new byte
        for (int i = 0; i < 3 * FRAME + 20; i++) step(1'b1, 8'($urandom), 1'b0);
        idle(6 * FRAME + 10);

        // Reset in the middle of a frame with bytes still queued
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        idle(34);
        step(1'b0, 8'h00, 1'b1);
        idle(FRAME + 20);

        // 0x00 then 0xFF after a long idle gap
        step(1'b1, 8'h00, 1'b0);
        idle(249);
        step(1'b1, 8'hFF, 1'b0);
        idle(FRAME + 10);

        // Random traffic with occasional resets and data changes between pushes
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 12, 8'($urandom), $urandom_range(0, 1499) == 0);
        end
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 80, 8'($urandom), 1'b0);
        end
        idle(6 * FRAME + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
